fetch_pc_ctrl: RTL and testbench

Front-end fetch controller that sits directly upstream of the instruction buffer. It owns the fetch PC and issues one 16-byte fetch request per `fetch_inst` demand to the icache arbiter. It realigns the returned 128-bit block so the instruction at the fetch PC lands in slot 0, and presents `aligned_instr`/`aligned_instr_valid`/`pc` to the ibuffer. It also handles pipeline redirects, including dropping in-flight responses.

---
 rtl/fetch_pc_ctrl_pkg.sv | 25 ++
 rtl/fetch_pc_ctrl_align.sv | 28 ++
 rtl/fetch_pc_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg
//   Shared frontend package for the fetch controller slice: FSM state
//   encoding and the fetch block geometry. Also provides the shared range
//   defines `PC_RANGE and `ICACHE_FETCHWIDTH128_RANGE when no project
//   defines header has already supplied them.
`ifndef PC_RANGE
`define PC_RANGE 63:0
`endif
`ifndef ICACHE_FETCHWIDTH128_RANGE
`define ICACHE_FETCHWIDTH128_RANGE 127:0
`endif

package fetch_pc_ctrl_pkg;

  localparam int unsigned FETCH_BLOCK_BYTES = 16;
  localparam int unsigned FETCH_WORDS       = FETCH_BLOCK_BYTES / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_ctrl_align.sv
// fetch_align
//   Combinational word shifter. Moves 32-bit word k of a 16-byte fetch block
//   into slot 0, zero-fills the vacated upper slots, and reports which slots
//   hold real instructions.
//   Ports:
//     data    in  128  fetch block, word 0 in [31:0]
//     k       in  2    word offset of the fetch PC inside the block
//     aligned out 128  data shifted down by k words
//     mask    out 4    slot valid mask, 4'b1111 >> k
`ifndef ICACHE_FETCHWIDTH128_RANGE
`define ICACHE_FETCHWIDTH128_RANGE 127:0
`endif

module fetch_align
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [`ICACHE_FETCHWIDTH128_RANGE] data,
  input  logic [1:0]                         k,
  output logic [`ICACHE_FETCHWIDTH128_RANGE] aligned,
  output logic [FETCH_WORDS-1:0]             mask
);

  always_comb begin
    aligned = data >> {k, 5'b0};
    mask    = {FETCH_WORDS{1'b1}} >> k;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
//   Front-end fetch controller upstream of the instruction buffer. Owns the
//   fetch PC, issues one 16-byte block request per demand, realigns the
//   returned block so the fetch-PC instruction is in slot 0, and squashes
//   in-flight responses on redirect.
//   Optional feature: define FETCH_PERF_CNT_EN to add perf_fetch_cnt /
//   perf_kill_cnt (delivered / dropped responses, wrapping 32-bit).
//   Ports:
//     clock, reset                  rising-edge clock, sync active-high reset
//     fetch_inst                    demand from ibuffer
//     redirect_valid/target         flush and restart at target
//     mem_stall                     blocks launching a new request
//     pc_index_valid/pc_index/ready request handshake to icache arbiter
//     pc_operation_done/icache_rdata one-cycle response with 128-bit block
//     aligned_instr/_valid/pc       registered realigned output to ibuffer
`ifndef PC_RANGE
`define PC_RANGE 63:0
`endif
`ifndef ICACHE_FETCHWIDTH128_RANGE
`define ICACHE_FETCHWIDTH128_RANGE 127:0
`endif

module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               fetch_inst,
  input  logic                               redirect_valid,
  input  logic [`PC_RANGE]                   redirect_target,
  input  logic                               mem_stall,
  output logic                               pc_index_valid,
  output logic [`PC_RANGE]                   pc_index,
  input  logic                               pc_index_ready,
  input  logic                               pc_operation_done,
  input  logic [`ICACHE_FETCHWIDTH128_RANGE] icache_rdata,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                        perf_fetch_cnt,
  output logic [31:0]                        perf_kill_cnt,
`endif
  output logic [`ICACHE_FETCHWIDTH128_RANGE] aligned_instr,
  output logic [3:0]                         aligned_instr_valid,
  output logic [`PC_RANGE]                   pc
);

  fetch_state_t state_q, state_d;
  logic [`PC_RANGE] fetch_pc_q;
  logic             req_pending_q;
  logic             handshake;
  logic             resp_take;

  logic [`ICACHE_FETCHWIDTH128_RANGE] align_data;
  logic [FETCH_WORDS-1:0]             align_mask;

  assign pc_index_valid = (state_q == REQ);
  assign pc_index       = {fetch_pc_q[63:4], 4'b0};

  // fetch_pc cannot change between the handshake and the response without a
  // redirect (which kills the response), so fetch_pc doubles as the latched
  // request PC and no separate req_pc register is kept.
  fetch_align u_align (
    .data    (icache_rdata),
    .k       (fetch_pc_q[3:2]),
    .aligned (align_data),
    .mask    (align_mask)
  );

  always_comb begin
    state_d   = state_q;
    handshake = 1'b0;
    resp_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && req_pending_q && !mem_stall) state_d = REQ;
      end
      REQ: begin
        handshake = pc_index_ready;
        if (redirect_valid)      state_d = pc_index_ready ? KILL : IDLE;
        else if (pc_index_ready) state_d = WAIT;
      end
      WAIT: begin
        if (pc_operation_done) begin
          state_d   = IDLE;
          resp_take = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (pc_operation_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= IDLE;
      fetch_pc_q          <= RESET_PC;
      req_pending_q       <= 1'b1;
      aligned_instr       <= '0;
      aligned_instr_valid <= '0;
      pc                  <= '0;
    end else begin
      state_q             <= state_d;
      aligned_instr_valid <= '0;
      if (redirect_valid) begin
        fetch_pc_q    <= redirect_target;
        req_pending_q <= 1'b1;
      end else begin
        // A demand arriving on the handshake cycle survives as the next request.
        if (fetch_inst)     req_pending_q <= 1'b1;
        else if (handshake) req_pending_q <= 1'b0;
        if (resp_take) begin
          aligned_instr       <= align_data;
          aligned_instr_valid <= align_mask;
          pc                  <= fetch_pc_q;
          fetch_pc_q          <= {fetch_pc_q[63:4], 4'b0} + 64'(FETCH_BLOCK_BYTES);
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic resp_drop;

  assign resp_drop = pc_operation_done &&
                     ((state_q == KILL) || ((state_q == WAIT) && redirect_valid));

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (resp_take) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (resp_drop) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl
//   Self-checking bench for fetch_pc_ctrl (RESET_PC overridden to
//   0x8000_0004). A transaction-level reference model tracks the fetch PC,
//   the pending demand, the presented request and the outstanding response;
//   directed scenarios are followed by randomized stimulus.
//   Honours FETCH_PERF_CNT_EN for the optional counter ports.
module tb_fetch_pc_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0004;

  logic         clock = 1'b0;
  logic         reset;
  logic         fetch_inst;
  logic         redirect_valid;
  logic [63:0]  redirect_target;
  logic         mem_stall;
  logic         pc_index_valid;
  logic [63:0]  pc_index;
  logic         pc_index_ready;
  logic         pc_operation_done;
  logic [127:0] icache_rdata;
  logic [127:0] aligned_instr;
  logic [3:0]   aligned_instr_valid;
  logic [63:0]  pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_fetch_cnt;
  logic [31:0]  perf_kill_cnt;
`endif

  always #5 clock = ~clock;

  fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .clock               (clock),
    .reset               (reset),
    .fetch_inst          (fetch_inst),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .mem_stall           (mem_stall),
    .pc_index_valid      (pc_index_valid),
    .pc_index            (pc_index),
    .pc_index_ready      (pc_index_ready),
    .pc_operation_done   (pc_operation_done),
    .icache_rdata        (icache_rdata),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt      (perf_fetch_cnt),
    .perf_kill_cnt       (perf_kill_cnt),
`endif
    .aligned_instr       (aligned_instr),
    .aligned_instr_valid (aligned_instr_valid),
    .pc                  (pc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: what the controller should be doing, in transaction terms.
  logic [63:0]  m_fpc;
  logic [63:0]  m_req_pc;
  logic         m_pending;
  logic         m_issuing;      // request presented to the arbiter
  logic         m_outstanding;  // request accepted, response not yet seen
  logic         m_doomed;       // outstanding response must be discarded
  logic [3:0]   e_aiv;
  logic [127:0] e_ai;
  logic [63:0]  e_pc;
  int unsigned  m_fetches;
  int unsigned  m_kills;

  task automatic model_update();
    logic hs, iss0, busy0;
    int   k;
    if (reset) begin
      m_fpc = RST_PC; m_req_pc = '0; m_pending = 1'b1; m_issuing = 1'b0;
      m_outstanding = 1'b0; m_doomed = 1'b0;
      e_aiv = '0; e_ai = '0; e_pc = '0; m_fetches = 0; m_kills = 0;
      return;
    end
    iss0  = m_issuing;
    busy0 = m_outstanding;
    hs    = iss0 && pc_index_ready;
    e_aiv = '0;
    if (busy0 && pc_operation_done) begin
      m_outstanding = 1'b0;
      if (m_doomed || redirect_valid) begin
        m_kills++;
      end else begin
        k     = int'(m_req_pc[3:2]);
        e_aiv = 4'hF >> k;
        e_pc  = m_req_pc;
        for (int i = 0; i < 4; i++)
          e_ai[32*i +: 32] = (i + k < 4) ? icache_rdata[32*(i+k) +: 32] : 32'h0;
        m_fpc = (m_req_pc & ~64'hF) + 64'd16;
        m_fetches++;
      end
      m_doomed = 1'b0;
    end else if (busy0 && redirect_valid) begin
      m_doomed = 1'b1;
    end
    if (iss0) begin
      if (hs) begin
        m_issuing = 1'b0; m_outstanding = 1'b1;
        m_doomed = redirect_valid; m_req_pc = m_fpc;
      end else if (redirect_valid) begin
        m_issuing = 1'b0;
      end
    end else if (!busy0 && m_pending && !mem_stall && !redirect_valid) begin
      m_issuing = 1'b1;
    end
    if (redirect_valid) begin
      m_fpc = redirect_target; m_pending = 1'b1;
    end else if (fetch_inst) begin
      m_pending = 1'b1;
    end else if (hs) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("pc_index_valid", pc_index_valid, m_issuing);
    check_eq("pc_index", pc_index, m_fpc & ~64'hF);
    check_eq("aligned_valid", aligned_instr_valid, e_aiv);
    check_eq("aligned_instr", aligned_instr, e_ai);
    check_eq("pc", pc, e_pc);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, m_fetches);
    check_eq("perf_kill", perf_kill_cnt, m_kills);
`endif
  endtask

  // Inputs are already driven for this cycle; advance one clock and check.
  task automatic cycle();
    model_update();
    @(negedge clock);
    check_outputs();
  endtask

  // From idle with a pending demand and ready high: launch, accept, wait lat, respond.
  task automatic run_txn(input int lat);
    pc_index_ready = 1'b1;
    cycle();
    cycle();
    repeat (lat) cycle();
    pc_operation_done = 1'b1;
    cycle();
    pc_operation_done = 1'b0;
  endtask

  logic [127:0] blk;
  logic [63:0]  tgt;

  initial begin
    blk = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001, 32'h9090_0000};
    reset = 1'b1; fetch_inst = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    mem_stall = 1'b0; pc_index_ready = 1'b0; pc_operation_done = 1'b0;
    icache_rdata = blk;
    repeat (2) cycle();
    check_eq("rst_piv", pc_index_valid, 1'b0);
    check_eq("rst_aiv", aligned_instr_valid, 4'h0);
    check_eq("rst_pc", pc, 64'h0);

    // First request after reset at a mid-block PC.
    reset = 1'b0; pc_index_ready = 1'b1;
    cycle();
    check_eq("t1_piv", pc_index_valid, 1'b1);
    check_eq("t1_idx", pc_index, 64'h8000_0000);
    cycle();
    cycle();
    pc_operation_done = 1'b1; cycle(); pc_operation_done = 1'b0;
    check_eq("t1_aiv", aligned_instr_valid, 4'b0111);
    check_eq("t1_pc", pc, 64'h8000_0004);
    check_eq("t1_slot0", aligned_instr[31:0], 32'hA1A1_0001);
    cycle();
    check_eq("t1_next_idx", pc_index, 64'h8000_0010);
    check_eq("t1_pulse_len", aligned_instr_valid, 4'h0);

    // Sequential blocks from 0x8000_0000.
    redirect_valid = 1'b1; redirect_target = 64'h8000_0000; cycle(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_txn(1);
      check_eq("t2_aiv", aligned_instr_valid, 4'hF);
      check_eq("t2_pc", pc, 64'h8000_0000 + 64'(16 * i));
      fetch_inst = 1'b1; cycle(); fetch_inst = 1'b0;
    end

    // Redirect during WAIT, response 3 cycles later is dropped.
    cycle(); cycle();
    redirect_valid = 1'b1; redirect_target = 64'h8000_100C; cycle(); redirect_valid = 1'b0;
    cycle(); cycle();
    pc_operation_done = 1'b1; cycle(); pc_operation_done = 1'b0;
    check_eq("t3_drop", aligned_instr_valid, 4'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("t3_kill_cnt", perf_kill_cnt, 32'd1);
`endif
    cycle();
    check_eq("t3_idx", pc_index, 64'h8000_1000);
    cycle();
    pc_operation_done = 1'b1; cycle(); pc_operation_done = 1'b0;
    check_eq("t3_aiv", aligned_instr_valid, 4'b0001);
    check_eq("t3_pc", pc, 64'h8000_100C);

    // Redirect on the same cycle as the response.
    fetch_inst = 1'b1; cycle(); fetch_inst = 1'b0;
    cycle(); cycle();
    pc_operation_done = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h8000_2040;
    cycle();
    pc_operation_done = 1'b0; redirect_valid = 1'b0;
    check_eq("t4_drop", aligned_instr_valid, 4'h0);
    check_eq("t4_idle", pc_index_valid, 1'b0);
    run_txn(0);
    check_eq("t4_pc", pc, 64'h8000_2040);

    // mem_stall holds off the launch.
    fetch_inst = 1'b1; cycle(); fetch_inst = 1'b0;
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("t5_stall_piv", pc_index_valid, 1'b0);
    end
    mem_stall = 1'b0;
    cycle();
    check_eq("t5_launch", pc_index_valid, 1'b1);
    cycle();
    pc_operation_done = 1'b1; cycle(); pc_operation_done = 1'b0;
    check_eq("t5_pc", pc, 64'h8000_2050);

    // Arbiter back-pressure; demands during the wait fold into one more request.
    fetch_inst = 1'b1; cycle(); fetch_inst = 1'b0;
    pc_index_ready = 1'b0;
    cycle();
    for (int c = 0; c < 4; c++) begin
      fetch_inst = (c == 1 || c == 3);
      cycle();
      fetch_inst = 1'b0;
      check_eq("t6_hold_piv", pc_index_valid, 1'b1);
      check_eq("t6_hold_idx", pc_index, 64'h8000_2060);
    end
    pc_index_ready = 1'b1; fetch_inst = 1'b1; cycle(); fetch_inst = 1'b0;
    pc_operation_done = 1'b1; cycle(); pc_operation_done = 1'b0;
    check_eq("t6_pc", pc, 64'h8000_2060);
    run_txn(0);
    check_eq("t6_extra_pc", pc, 64'h8000_2070);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check_eq("t6_no_more", pc_index_valid, 1'b0);
    end

    // Fetch PC wraps past the top of the address space.
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFF8; cycle(); redirect_valid = 1'b0;
    run_txn(0);
    check_eq("t7_aiv", aligned_instr_valid, 4'b0011);
    check_eq("t7_pc", pc, 64'hFFFF_FFFF_FFFF_FFF8);
    cycle();
    check_eq("t7_wrap_idx", pc_index, 64'h0);

    // Randomized traffic, including occasional mid-operation reset.
    for (int n = 0; n < 4000; n++) begin
      reset             = ($urandom_range(0, 399) == 0);
      fetch_inst        = ($urandom_range(0, 2) == 0);
      mem_stall         = ($urandom_range(0, 3) == 0);
      pc_index_ready    = ($urandom_range(0, 1) == 0);
      pc_operation_done = ($urandom_range(0, 2) == 0);
      redirect_valid    = ($urandom_range(0, 19) == 0);
      tgt = {$urandom, $urandom};
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tgt[63:4] = '1;
      redirect_target = tgt;
      icache_rdata    = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
